// File: rtl/ysyx_23060124_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_pkg
// Brief    : Shared WBU types: FSM encoding, load funct3 codes, error causes.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060124_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_COMMIT    = 2'd2
    } wbu_state_t;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_ACCESS     = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060124_wbu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_wbu_if
// Brief    : Retire handshake, load response and register-file write bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_23060124_wbu_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [RA_W-1:0] in_rd;
    logic            in_rd_wen;
    logic            in_is_load;
    logic [2:0]      in_ld_fn;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_pc;

    logic            mem_rvalid;
    logic            mem_rready;
    logic [XLEN-1:0] mem_rdata;
    logic [1:0]      mem_rresp;

    logic            wen;
    logic [RA_W-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic            load_pending;
    logic [RA_W-1:0] pending_rd;
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic            err_valid;
    logic [1:0]      err_cause;

    modport slave (
        input  in_valid, in_rd, in_rd_wen, in_is_load, in_ld_fn, in_addr_lo,
               in_result, in_pc, mem_rvalid, mem_rdata, mem_rresp,
        output in_ready, mem_rready, wen, waddr, wdata, load_pending,
               pending_rd, retire_valid, retire_pc, err_valid, err_cause
    );

    modport master (
        output in_valid, in_rd, in_rd_wen, in_is_load, in_ld_fn, in_addr_lo,
               in_result, in_pc, mem_rvalid, mem_rdata, mem_rresp,
        input  in_ready, mem_rready, wen, waddr, wdata, load_pending,
               pending_rd, retire_valid, retire_pc, err_valid, err_cause
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060124_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_load_ext
// Brief    : Combinational load formatter: lane select, extension, alignment.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060124_load_ext
    import ysyx_23060124_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      ld_fn,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown funct3 codes fall into the word case, alignment rule included.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ld_fn)
            LD_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LD_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            LD_LH: begin
                data       = {{(XLEN-16){w_half[15]}}, w_half};
                misaligned = addr_lo[0];
            end
            LD_LHU: begin
                data       = {{(XLEN-16){1'b0}}, w_half};
                misaligned = addr_lo[0];
            end
            default: begin
                data       = rdata;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060124_wbu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_wbu
// Brief    : RV32E write-back stage: load completion, regfile write, retire.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060124_wbu
    import ysyx_23060124_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 4
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060124_wbu_if.slave bus
);

    wbu_state_t      r_state;
    wbu_state_t      w_next;

    logic [RA_W-1:0] r_rd;
    logic            r_rd_wen;
    logic [2:0]      r_ld_fn;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc;
    logic            r_err;
    logic [1:0]      r_cause;

    logic            w_capture;
    logic            w_accept;
    logic            w_resp_err;
    logic [XLEN-1:0] w_ld_data;
    logic            w_misaligned;

    assign w_capture  = bus.in_valid && (r_state != ST_WAIT_RESP);
    assign w_accept   = bus.mem_rvalid && (r_state == ST_WAIT_RESP);
    assign w_resp_err = (bus.mem_rresp != 2'b00);

    ysyx_23060124_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata      (bus.mem_rdata),
        .ld_fn      (r_ld_fn),
        .addr_lo    (r_addr_lo),
        .data       (w_ld_data),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_COMMIT: begin
                if (bus.in_valid) begin
                    w_next = bus.in_is_load ? ST_WAIT_RESP : ST_COMMIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.mem_rvalid) begin
                    w_next = ST_COMMIT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture and response acceptance are mutually exclusive by state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd      <= '0;
            r_rd_wen  <= 1'b0;
            r_ld_fn   <= 3'b000;
            r_addr_lo <= 2'b00;
            r_wdata   <= '0;
            r_pc      <= '0;
            r_err     <= 1'b0;
            r_cause   <= ERR_NONE;
        end else if (w_capture) begin
            r_rd      <= bus.in_rd;
            r_rd_wen  <= bus.in_rd_wen;
            r_ld_fn   <= bus.in_ld_fn;
            r_addr_lo <= bus.in_addr_lo;
            r_wdata   <= bus.in_is_load ? '0 : bus.in_result;
            r_pc      <= bus.in_pc;
            r_err     <= 1'b0;
            r_cause   <= ERR_NONE;
        end else if (w_accept) begin
            r_wdata   <= w_ld_data;
            r_err     <= w_misaligned || w_resp_err;
            r_cause   <= w_misaligned ? ERR_MISALIGNED :
                         (w_resp_err ? ERR_ACCESS : ERR_NONE);
        end
    end

    assign bus.waddr     = r_rd;
    assign bus.wdata     = r_wdata;
    assign bus.retire_pc = r_pc;

    always_comb begin
        bus.in_ready     = 1'b1;
        bus.mem_rready   = 1'b0;
        bus.load_pending = 1'b0;
        bus.pending_rd   = '0;
        bus.retire_valid = 1'b0;
        bus.wen          = 1'b0;
        bus.err_valid    = 1'b0;
        bus.err_cause    = ERR_NONE;
        case (r_state)
            ST_WAIT_RESP: begin
                bus.in_ready     = 1'b0;
                bus.mem_rready   = 1'b1;
                bus.load_pending = 1'b1;
                bus.pending_rd   = r_rd;
            end
            ST_COMMIT: begin
                bus.retire_valid = 1'b1;
                bus.wen          = r_rd_wen && (r_rd != '0) && !r_err;
                bus.err_valid    = r_err;
                bus.err_cause    = r_err ? r_cause : ERR_NONE;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
